cache_way_param: RTL and testbench

//   Parametrised, self-contained cache way: tag RAM, valid bits and data RAM for

---
 rtl/cache_way_param.sv | 223 ++++++++++++++++++++++
 tb/tb_cache_way_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_way_param.sv
// ---------------------------------------------------------------------------
// cache_way_param
//   One way of a set-associative cache: tag RAM, valid bits and data RAM for
//   SETS lines of BLOCK_BYTES words. Provides a single-cycle registered lookup
//   with hit detection, write-on-hit, per-line invalidate and a line-fill
//   engine with a valid/ready beat handshake.
//
// Configuration macro:
//   CACHE_WAY_PARITY_EN  store one even-parity bit per word and add par_err.
//                        A lookup whose tag matches but whose parity is bad
//                        reports hit=0, dout=0, par_err=1.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   enable      0 freezes the way: requests ignored, FSM and counter hold
//   addr        {tag, index, offset} for rd/wr/inv/fill_start
//   rd_req      lookup request           -> rd_valid/hit/dout next cycle
//   wr_req      write request            -> wr_hit next cycle (write on hit)
//   din         write data
//   dout        registered read data (0 on miss)
//   rd_valid    pulse: dout/hit valid for the previous rd_req
//   hit         registered hit result, qualified by rd_valid
//   wr_hit      pulse: previous wr_req hit and was written
//   inv         invalidate the line at addr index (aborts a fill)
//   fill_start  begin a line fill for addr tag/index
//   fill_valid  fill beat present
//   fill_data   fill beat data, offsets 0..BLOCK_BYTES-1 in order
//   fill_ready  way accepts fill beats
//   fill_done   pulse: line filled and marked valid
//   busy        fill in progress
//   par_err     (parity build only) pulse with rd_valid on parity error
// ---------------------------------------------------------------------------
module cache_way_param #(
  parameter int SETS        = 256,
  parameter int BLOCK_BYTES = 16,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              hit,
  output logic              wr_hit,
  input  logic              inv,
  input  logic              fill_start,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_ready,
  output logic              fill_done,
  output logic              busy
`ifdef CACHE_WAY_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS = SETS * BLOCK_BYTES;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_nxt;

  // Address fields
  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;

  assign a_tag = addr[ADDR_W-1 -: TAG_W];
  assign a_idx = addr[OFF_W +: IDX_W];
  assign a_off = addr[OFF_W-1:0];

  // Storage
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_ram  [SETS];
  logic [DATA_W-1:0] data_ram [WORDS];
`ifdef CACHE_WAY_PARITY_EN
  logic              par_ram  [WORDS];
`endif

  // Fill engine registers
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [OFF_W-1:0] cnt;

  // Lookup
  logic [DATA_W-1:0] rd_word;
  logic              tag_match;
  logic              lookup_hit;

  assign rd_word   = data_ram[{a_idx, a_off}];
  assign tag_match = valid[a_idx] && (tag_ram[a_idx] == a_tag);

`ifdef CACHE_WAY_PARITY_EN
  logic par_ok;
  assign par_ok     = ((^rd_word) == par_ram[{a_idx, a_off}]);
  assign lookup_hit = tag_match && par_ok;
`else
  assign lookup_hit = tag_match;
`endif

  // Request decode: inv > fill_start > wr_req > rd_req; losers are dropped.
  // inv is honoured in FILL as well, where it aborts the fill.
  logic in_idle, do_inv, do_fill_start, do_wr, do_rd, beat, last_beat;

  assign in_idle       = (state == IDLE);
  assign do_inv        = enable && inv;
  assign do_fill_start = enable && in_idle && !inv && fill_start;
  assign do_wr         = enable && in_idle && !inv && !fill_start && wr_req;
  assign do_rd         = enable && in_idle && !inv && !fill_start && !wr_req && rd_req;
  // A beat arriving together with an abort is discarded.
  assign beat          = fill_ready && fill_valid && !inv;
  assign last_beat     = beat && (&cnt);

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM: next-state logic
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (do_fill_start) state_nxt = FILL;
      FILL: if (do_inv || last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. fill_ready is gated by enable so a frozen way takes no beats.
  always_comb begin
    busy       = 1'b0;
    fill_ready = 1'b0;
    if (state == FILL) begin
      busy       = 1'b1;
      fill_ready = enable;
    end
  end

  // Fill engine: latched target line and beat counter. The counter is OFF_W
  // bits wide and wraps to 0 on the last beat.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_tag <= '0;
      fill_idx <= '0;
      cnt      <= '0;
    end else if (do_fill_start) begin
      fill_tag <= a_tag;
      fill_idx <= a_idx;
      cnt      <= '0;
    end else if (beat) begin
      cnt <= cnt + OFF_W'(1);
    end
  end

  // Valid bits: the only per-line state that needs a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (do_inv || do_fill_start) begin
      valid[a_idx] <= 1'b0;
    end else if (last_beat) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data RAMs have no reset; clearing valid is enough and keeps them mappable to SRAM.
  always_ff @(posedge clk) begin
    if (last_beat) tag_ram[fill_idx] <= fill_tag;
  end

  // Writes qualify on tag/valid only, so a write also repairs a word with bad parity.
  always_ff @(posedge clk) begin
    if (do_wr && tag_match) begin
      data_ram[{a_idx, a_off}] <= din;
`ifdef CACHE_WAY_PARITY_EN
      par_ram[{a_idx, a_off}]  <= ^din;
`endif
    end else if (beat) begin
      data_ram[{fill_idx, cnt}] <= fill_data;
`ifdef CACHE_WAY_PARITY_EN
      par_ram[{fill_idx, cnt}]  <= ^fill_data;
`endif
    end
  end

  // Registered response outputs. dout holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout      <= '0;
      rd_valid  <= 1'b0;
      hit       <= 1'b0;
      wr_hit    <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      rd_valid  <= do_rd;
      hit       <= do_rd && lookup_hit;
      wr_hit    <= do_wr && tag_match;
      fill_done <= last_beat;
      if (do_rd) dout <= lookup_hit ? rd_word : '0;
    end
  end

`ifdef CACHE_WAY_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err <= 1'b0;
    else      par_err <= do_rd && tag_match && !par_ok;
  end
`endif

endmodule

// File: tb/tb_cache_way_param.sv
// ---------------------------------------------------------------------------
// tb_cache_way_param
//   Directed bench for cache_way_param (default parameters). A small model of
//   valid/tag/data predicts each read; predictions are queued when the read is
//   driven and compared when the DUT raises rd_valid.
// ---------------------------------------------------------------------------
module tb_cache_way_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] addr;
  logic        rd_req, wr_req, inv, fill_start, fill_valid;
  logic [7:0]  din, fill_data;
  logic [7:0]  dout;
  logic        rd_valid, hit, wr_hit, fill_ready, fill_done, busy;
`ifdef CACHE_WAY_PARITY_EN
  logic        par_err;
`endif

  cache_way_param #(
    .SETS(256), .BLOCK_BYTES(16), .DATA_W(8), .ADDR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .addr(addr),
    .rd_req(rd_req), .wr_req(wr_req), .din(din), .dout(dout),
    .rd_valid(rd_valid), .hit(hit), .wr_hit(wr_hit), .inv(inv),
    .fill_start(fill_start), .fill_valid(fill_valid), .fill_data(fill_data),
    .fill_ready(fill_ready), .fill_done(fill_done), .busy(busy)
`ifdef CACHE_WAY_PARITY_EN
    , .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic       hit;
    logic [7:0] dout;
    logic       perr;
  } exp_t;

  exp_t sb[$];

  // Reference model: address = {tag[15:12], idx[11:4], off[3:0]}
  bit         m_valid [256];
  logic [3:0] m_tag   [256];
  logic [7:0] m_data  [4096];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [15:0] a);
    return m_valid[a[11:4]] && (m_tag[a[11:4]] == a[15:12]);
  endfunction

  // Response monitor, sampling 3 ns after the rising edge.
  always @(posedge clk) begin
    #3;
    if (rst && fill_done) done_cnt++;
    if (rst && rd_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_hit", {31'd0, hit}, {31'd0, e.hit});
        check("rd_dout", {24'd0, dout}, {24'd0, e.dout});
`ifdef CACHE_WAY_PARITY_EN
        check("rd_par_err", {31'd0, par_err}, {31'd0, e.perr});
`endif
      end
    end
  end

  // Advance to the next falling edge and drop all one-cycle requests.
  task automatic cycle();
    @(negedge clk);
    enable     = 1'b1;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    inv        = 1'b0;
    fill_start = 1'b0;
    fill_valid = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    exp_t e;
    cycle();
    addr   = a;
    rd_req = 1'b1;
    e.hit  = model_hit(a);
    e.dout = e.hit ? m_data[a[11:0]] : 8'h00;
    e.perr = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bit exp_hit;
    cycle();
    addr    = a;
    din     = d;
    wr_req  = 1'b1;
    exp_hit = model_hit(a);
    if (exp_hit) m_data[a[11:0]] = d;
    cycle();
    check("wr_hit", {31'd0, wr_hit}, {31'd0, exp_hit});
  endtask

  // Line fill. stop_at=16 completes; fewer beats then aborts with inv, or
  // with an asynchronous reset when use_rst is set. gappy toggles fill_valid
  // every other cycle, freezes the way for 3 cycles and issues ignored reads.
  task automatic fill(input logic [15:0] a, input logic [7:0] base, input bit gappy,
                      input int stop_at, input bit use_rst);
    int sent  = 0;
    int cyc   = 0;
    int done0 = done_cnt;
    bit en, fv;
    cycle();
    addr       = a;
    fill_start = 1'b1;
    m_valid[a[11:4]] = 1'b0;
    cycle();
    check("fill_busy_start", {31'd0, busy}, 32'd1);
    check("fill_ready_start", {31'd0, fill_ready}, 32'd1);
    while (sent < stop_at && cyc < 200) begin
      en = !(gappy && cyc >= 4 && cyc <= 6);
      fv = gappy ? (cyc % 2 == 0) : 1'b1;
      enable     = en;
      fill_valid = fv;
      fill_data  = base + 8'(sent);
      if (gappy) begin
        addr   = a;
        rd_req = 1'b1;
      end
      if (gappy && cyc == 4) begin
        #1;
        check("fill_ready_frozen", {31'd0, fill_ready}, 32'd0);
      end
      if (en && fv) sent++;
      cyc++;
      cycle();
    end
    if (cyc >= 200) check("fill_cycle_budget", 32'd1, 32'd0);
    if (stop_at == 16) begin
      check("fill_done_pulse", {31'd0, fill_done}, 32'd1);
      check("fill_busy_end", {31'd0, busy}, 32'd0);
      check("fill_ready_end", {31'd0, fill_ready}, 32'd0);
      for (int i = 0; i < 16; i++) m_data[{a[11:4], 4'(i)}] = base + 8'(i);
      m_tag[a[11:4]]   = a[15:12];
      m_valid[a[11:4]] = 1'b1;
      cycle();
      check("fill_done_count", done_cnt, done0 + 1);
    end else if (!use_rst) begin
      addr       = a;
      inv        = 1'b1;
      fill_valid = 1'b1;
      fill_data  = 8'hEE;
      cycle();
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_no_done", done_cnt, done0);
    end else begin
      rst = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_fill_ready", {31'd0, fill_ready}, 32'd0);
      for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      cycle();
      check("rst_no_done", done_cnt, done0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; enable = 1'b1; addr = '0; din = '0; fill_data = '0;
    rd_req = 1'b0; wr_req = 1'b0; inv = 1'b0; fill_start = 1'b0; fill_valid = 1'b0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cycle();

    // 1. Reset state and a cold miss.
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_wr_hit", {31'd0, wr_hit}, 32'd0);
    check("rst_fill_ready", {31'd0, fill_ready}, 32'd0);
    check("rst_fill_done", {31'd0, fill_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rd(16'h1234);

    // 2. Plain fill, then back-to-back reads.
    fill(16'h1230, 8'h00, 1'b0, 16, 1'b0);
    rd(16'h1235);
    rd(16'h1230);
    rd(16'h123F);

    // 3. Write hit, write miss on the same index, priority and freeze.
    wr(16'h1235, 8'hA5);
    rd(16'h1235);
    wr(16'h2235, 8'h5A);
    rd(16'h1235);
    rd(16'h2235);
    cycle();                       // wr_req wins over rd_req
    addr = 16'h1236; din = 8'h3C; wr_req = 1'b1; rd_req = 1'b1;
    m_data[12'h236] = 8'h3C;
    cycle();
    check("prio_wr_hit", {31'd0, wr_hit}, 32'd1);
    rd(16'h1236);
    cycle();                       // frozen way ignores a read
    enable = 1'b0; addr = 16'h1236; rd_req = 1'b1;

    // 4. Gappy fill with freeze, then an aborted fill.
    fill(16'h4560, 8'h80, 1'b1, 16, 1'b0);
    rd(16'h4567);
    rd(16'h456F);
    fill(16'h7890, 8'h40, 1'b0, 5, 1'b0);
    rd(16'h7893);

    // 5. Reset mid-fill, then invalidate a valid line.
    fill(16'hABC0, 8'h20, 1'b0, 8, 1'b1);
    rd(16'hABC4);
    rd(16'h1235);
    fill(16'h1230, 8'h10, 1'b0, 16, 1'b0);
    rd(16'h1232);
    cycle();                       // inv wins over rd_req in the same cycle
    addr = 16'h1230; inv = 1'b1; rd_req = 1'b1;
    m_valid[8'h23] = 1'b0;
    rd(16'h1232);
    cycle();                       // inv on an already-invalid line
    addr = 16'h1230; inv = 1'b1;
    rd(16'h1232);

`ifdef CACHE_WAY_PARITY_EN
    // 6. Corrupted parity turns a hit into a parity error.
    fill(16'h3330, 8'h61, 1'b0, 16, 1'b0);
    rd(16'h3334);
    cycle();
    dut.par_ram[12'h334] = ~dut.par_ram[12'h334];
    begin
      exp_t e;
      cycle();
      addr = 16'h3334; rd_req = 1'b1;
      e.hit = 1'b0; e.dout = 8'h00; e.perr = 1'b1;
      sb.push_back(e);
    end
    wr(16'h3334, 8'h77);
    rd(16'h3334);
`endif

    cycle();
    cycle();
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
